// File: rtl/cksum_check.sv
// cksum_check: reads a field from packet SRAM and verifies its 16-bit
// one's-complement Internet checksum. Read-only SRAM master.
//
// state  | meaning
// S_FREE | idle, waiting for start_i
// S_SUM  | issuing word reads and accumulating returned halfwords
// S_FOLD1| first carry fold of the 32-bit accumulator
// S_FOLD2| second fold, result and flags registered
// S_DONE | result held until start_i is released
module cksum_check #(
  parameter int unsigned MAX_LEN = 1500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] field_start_i,
  input  logic [31:0] field_len_i,
  output logic        sram_ce_o,
  output logic        sram_we_o,
  output logic [31:0] sram_addr_o,
  output logic [3:0]  sram_sel_o,
  input  logic [31:0] sram_data_i,
  output logic        done_o,
  output logic        ok_o,
  output logic        err_o,
  output logic [15:0] sum_o
);

  typedef enum logic [2:0] {
    S_FREE  = 3'd0,
    S_SUM   = 3'd1,
    S_FOLD1 = 3'd2,
    S_FOLD2 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] cnt_q, cnt_d;       // reads still to issue after the current one
  logic        first_q, first_d;   // read being issued now is the first word
  logic        s1_q, s1_d;         // field starts on the low halfword
  logic [1:0]  elo_q, elo_d;       // end address bits [1:0]
  logic        ce_q, ce_d;
  logic        p1_vld_q, p1_vld_d; // read issued last cycle; data arrives next cycle
  logic        p1_first_q, p1_first_d;
  logic        p1_last_q, p1_last_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic [15:0] sum_q, sum_d;

  logic [31:0] end_addr;
  logic [31:0] word_cnt_m1;
  logic [15:0] hi_t, lo_t;
  logic [15:0] fold16;

  // Word count of the field, computed from the live request inputs
  always_comb begin
    end_addr    = field_start_i + field_len_i;
    word_cnt_m1 = ((end_addr - 32'd1) >> 2) - (field_start_i >> 2);
  end

  // Halfword masking of the returned word for partial first/last words
  always_comb begin
    hi_t = sram_data_i[31:16];
    lo_t = sram_data_i[15:0];
    if (p1_last_q) begin
      case (elo_q)
        2'd1: begin
          hi_t = {sram_data_i[31:24], 8'h00};
          lo_t = 16'h0000;
        end
        2'd2: lo_t = 16'h0000;
        2'd3: lo_t = {sram_data_i[15:8], 8'h00};
        default: ;
      endcase
    end
    if (p1_first_q && s1_q) hi_t = 16'h0000;
    fold16 = acc_q[31:16] + acc_q[15:0];
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    s1_d       = s1_q;
    elo_d      = elo_q;
    ce_d       = ce_q;
    p1_vld_d   = 1'b0;
    p1_first_d = 1'b0;
    p1_last_d  = 1'b0;
    done_d     = done_q;
    ok_d       = ok_q;
    err_d      = err_q;
    sum_d      = sum_q;
    case (state_q)
      S_FREE: begin
        if (start_i) begin
          acc_d = 32'd0;
          if (field_start_i[0] || (field_len_i > MAX_LEN)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            ok_d    = 1'b0;
            sum_d   = 16'h0000;
            state_d = S_DONE;
          end else if (field_len_i == 32'd0) begin
            state_d = S_FOLD1;
          end else begin
            ce_d    = 1'b1;
            addr_d  = {field_start_i[31:2], 2'b00};
            cnt_d   = word_cnt_m1;
            first_d = 1'b1;
            s1_d    = field_start_i[1];
            elo_d   = end_addr[1:0];
            state_d = S_SUM;
          end
        end
      end
      S_SUM: begin
        p1_vld_d   = ce_q;
        p1_first_d = ce_q && first_q;
        p1_last_d  = ce_q && (cnt_q == 32'd0);
        first_d    = 1'b0;
        if (ce_q) begin
          if (cnt_q != 32'd0) begin
            addr_d = addr_q + 32'd4;
            cnt_d  = cnt_q - 32'd1;
          end else begin
            ce_d = 1'b0;
          end
        end
        if (p1_vld_q) begin
          acc_d = acc_q + {16'h0000, hi_t} + {16'h0000, lo_t};
          if (p1_last_q) state_d = S_FOLD1;
        end
      end
      S_FOLD1: begin
        acc_d   = {15'd0, {1'b0, acc_q[31:16]} + {1'b0, acc_q[15:0]}};
        state_d = S_FOLD2;
      end
      S_FOLD2: begin
        sum_d   = fold16;
        ok_d    = (fold16 == 16'hFFFF);
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!start_i) begin
          done_d  = 1'b0;
          ok_d    = 1'b0;
          err_d   = 1'b0;
          sum_d   = 16'h0000;
          state_d = S_FREE;
        end
      end
      default: begin
        ce_d    = 1'b0;
        done_d  = 1'b0;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        sum_d   = 16'h0000;
        state_d = S_FREE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_FREE;
      acc_q      <= 32'd0;
      addr_q     <= 32'd0;
      cnt_q      <= 32'd0;
      first_q    <= 1'b0;
      s1_q       <= 1'b0;
      elo_q      <= 2'd0;
      ce_q       <= 1'b0;
      p1_vld_q   <= 1'b0;
      p1_first_q <= 1'b0;
      p1_last_q  <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      sum_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      s1_q       <= s1_d;
      elo_q      <= elo_d;
      ce_q       <= ce_d;
      p1_vld_q   <= p1_vld_d;
      p1_first_q <= p1_first_d;
      p1_last_q  <= p1_last_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      sum_q      <= sum_d;
    end
  end

  assign sram_ce_o   = ce_q;
  assign sram_we_o   = 1'b0;
  assign sram_sel_o  = 4'b0000;
  assign sram_addr_o = addr_q;
  assign done_o      = done_q;
  assign ok_o        = ok_q;
  assign err_o       = err_q;
  assign sum_o       = sum_q;

endmodule

// File: tb/tb_cksum_check.sv
// Testbench for cksum_check: byte-addressed SRAM model, byte-wise
// RFC 1071 reference checksum, and an expected-result queue.
`timescale 1ns/1ps
module tb_cksum_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] field_start_i, field_len_i;
  logic        sram_ce_o, sram_we_o;
  logic [31:0] sram_addr_o;
  logic [3:0]  sram_sel_o;
  logic [31:0] sram_data_i;
  logic        done_o, ok_o, err_o;
  logic [15:0] sum_o;

  cksum_check dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .field_start_i(field_start_i), .field_len_i(field_len_i),
    .sram_ce_o(sram_ce_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_sel_o(sram_sel_o), .sram_data_i(sram_data_i),
    .done_o(done_o), .ok_o(ok_o), .err_o(err_o), .sum_o(sum_o)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:4095];
  logic [7:0] hdr [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                           8'hb8, 8'h61, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};

  // SRAM: data returned the cycle after ce+addr, big-endian
  always @(posedge clk) begin
    if (sram_ce_o)
      sram_data_i <= {mem[sram_addr_o[11:0]], mem[sram_addr_o[11:0] + 12'd1],
                      mem[sram_addr_o[11:0] + 12'd2], mem[sram_addr_o[11:0] + 12'd3]};
  end

  typedef struct {
    logic [15:0] sum;
    logic        ok;
    logic        err;
    int          lat;
    int          nrd;
    logic [31:0] a0;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  int          g_lat, g_nrd, g_gaps, g_first_ce;
  logic [31:0] g_a0, g_prev;
  logic        g_to, g_ok, g_err, g_we_bad;
  logic [15:0] g_sum;

  function automatic logic [15:0] model_sum(int s, int len);
    logic [31:0] acc;
    logic [15:0] hw;
    acc = 32'd0;
    for (int i = 0; i < len; i += 2) begin
      hw  = {mem[s + i], (i + 1 < len) ? mem[s + i + 1] : 8'h00};
      acc = acc + {16'h0000, hw};
    end
    while (acc[31:16] != 16'h0000) acc = {16'h0000, acc[31:16]} + {16'h0000, acc[15:0]};
    return acc[15:0];
  endfunction

  function automatic exp_t make_exp(int s, int len);
    exp_t e;
    e.a0 = 32'(s) & ~32'd3;
    if ((s % 2 == 1) || len > 1500) begin
      e.err = 1'b1; e.sum = 16'h0000; e.ok = 1'b0; e.lat = 1; e.nrd = 0;
    end else if (len == 0) begin
      e.err = 1'b0; e.sum = 16'h0000; e.ok = 1'b0; e.lat = 3; e.nrd = 0;
    end else begin
      e.err = 1'b0;
      e.sum = model_sum(s, len);
      e.ok  = (e.sum == 16'hFFFF);
      e.nrd = ((s + len - 1) / 4) - (s / 4) + 1;
      e.lat = e.nrd + 4;
    end
    return e;
  endfunction

  task automatic load_hdr(input int a);
    for (int i = 0; i < 20; i++) mem[a + i] = hdr[i];
  endtask

  // Drive one request and collect what the DUT does until done_o
  task automatic do_op(input int s, input int len, input bit drop_early);
    @(negedge clk);
    field_start_i = 32'(s);
    field_len_i   = 32'(len);
    start_i       = 1'b1;
    g_lat = 0; g_nrd = 0; g_gaps = 0; g_first_ce = 0; g_a0 = '0; g_prev = '0; g_we_bad = 1'b0;
    g_to = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      g_lat++;
      if (k == 0) begin
        field_start_i = 32'h0000_0101;
        field_len_i   = 32'hFFFF_FFFF;
      end
      if (drop_early && k == 2) start_i = 1'b0;
      if (sram_we_o !== 1'b0 || sram_sel_o !== 4'b0000) g_we_bad = 1'b1;
      if (sram_ce_o) begin
        if (g_nrd == 0) begin
          g_a0 = sram_addr_o;
          g_first_ce = g_lat;
        end else if (sram_addr_o !== g_prev + 32'd4) begin
          g_gaps++;
        end
        if (sram_addr_o[1:0] !== 2'b00) g_gaps++;
        g_prev = sram_addr_o;
        g_nrd++;
      end
      if (done_o === 1'b1) begin
        g_to = 1'b0;
        break;
      end
    end
    g_sum = sum_o; g_ok = ok_o; g_err = err_o;
  endtask

  task automatic release_op();
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; field_start_i = '0; field_len_i = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sram_ce_o, sram_we_o, done_o, ok_o, err_o} !== 5'b0 || sum_o !== 16'h0 ||
        sram_addr_o !== 32'h0 || sram_sel_o !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ce=%b we=%b done=%b ok=%b err=%b sum=%h addr=%h sel=%h want all zero",
               sram_ce_o, sram_we_o, done_o, ok_o, err_o, sum_o, sram_addr_o, sram_sel_o);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (done_o !== 1'b0 || sram_ce_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got done=%b ce=%b want 0 0", done_o, sram_ce_o);
    end
  endtask

  task automatic test_ipv4();
    int   starts [3] = '{32'h40, 32'h40, 32'h0E};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      load_hdr(starts[i]);
      if (i == 1) mem[12'h048] = 8'h41;
      sb.push_back(make_exp(starts[i], 20));
      do_op(starts[i], 20, 1'b0);
      e = sb.pop_front();
      n_checks++; if (g_to) begin n_fail++; $display("FAIL ipv4[%0d] timeout: done_o never rose", i); end
      n_checks++; if (g_sum !== e.sum) begin n_fail++; $display("FAIL ipv4[%0d] sum_o: got %h want %h", i, g_sum, e.sum); end
      n_checks++; if (g_ok !== e.ok || g_err !== 1'b0) begin n_fail++; $display("FAIL ipv4[%0d] flags: got ok=%b err=%b want ok=%b err=0", i, g_ok, g_err, e.ok); end
      n_checks++; if (g_lat !== e.lat) begin n_fail++; $display("FAIL ipv4[%0d] latency: got %0d want %0d", i, g_lat, e.lat); end
      n_checks++; if (g_nrd !== e.nrd || g_a0 !== e.a0 || g_first_ce !== 1 || g_gaps !== 0) begin
        n_fail++;
        $display("FAIL ipv4[%0d] reads: got n=%0d a0=%h first=%0d gaps=%0d want n=%0d a0=%h first=1 gaps=0",
                 i, g_nrd, g_a0, g_first_ce, g_gaps, e.nrd, e.a0);
      end
      n_checks++; if (i != 1 && g_sum !== 16'hFFFF) begin n_fail++; $display("FAIL ipv4[%0d] valid_header: got %h want ffff", i, g_sum); end
      n_checks++; if (g_we_bad) begin n_fail++; $display("FAIL ipv4[%0d] we_sel: got nonzero we/sel want 0", i); end
      release_op();
      mem[12'h048] = 8'h40;
    end
  endtask

  task automatic test_odd_len();
    int   ss [4] = '{32'h20, 32'h20, 32'h42, 32'h40};
    int   ll [4] = '{3, 0, 1, 1500};
    exp_t e;
    mem[12'h020] = 8'h01; mem[12'h021] = 8'h02; mem[12'h022] = 8'h03;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(make_exp(ss[i], ll[i]));
      do_op(ss[i], ll[i], i == 3);
      e = sb.pop_front();
      n_checks++; if (g_to) begin n_fail++; $display("FAIL odd[%0d] timeout: done_o never rose", i); end
      n_checks++; if (g_sum !== e.sum || g_ok !== e.ok || g_err !== 1'b0) begin
        n_fail++; $display("FAIL odd[%0d] result: got sum=%h ok=%b err=%b want sum=%h ok=%b err=0", i, g_sum, g_ok, g_err, e.sum, e.ok);
      end
      n_checks++; if (g_lat !== e.lat || g_nrd !== e.nrd || g_gaps !== 0) begin
        n_fail++; $display("FAIL odd[%0d] timing: got lat=%0d reads=%0d gaps=%0d want lat=%0d reads=%0d gaps=0", i, g_lat, g_nrd, g_gaps, e.lat, e.nrd);
      end
      if (i == 0) begin
        n_checks++; if (g_sum !== 16'h0402) begin n_fail++; $display("FAIL odd_len3 sum_o: got %h want 0402", g_sum); end
      end
      release_op();
    end
  endtask

  task automatic test_reject_hold();
    int   ss [2] = '{32'h21, 32'h40};
    int   ll [2] = '{20, 1501};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(make_exp(ss[i], ll[i]));
      do_op(ss[i], ll[i], 1'b0);
      e = sb.pop_front();
      n_checks++; if (g_to || g_err !== e.err || g_lat !== e.lat || g_nrd !== 0) begin
        n_fail++; $display("FAIL reject[%0d]: got to=%b err=%b lat=%0d reads=%0d want err=%b lat=%0d reads=0", i, g_to, g_err, g_lat, g_nrd, e.err, e.lat);
      end
      n_checks++; if (g_ok !== 1'b0 || g_sum !== 16'h0) begin
        n_fail++; $display("FAIL reject[%0d] result: got ok=%b sum=%h want 0 0000", i, g_ok, g_sum);
      end
      if (i == 0) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          n_checks++;
          if (done_o !== 1'b1 || err_o !== 1'b1 || ok_o !== 1'b0 || sum_o !== 16'h0 || sram_ce_o !== 1'b0) begin
            n_fail++; $display("FAIL hold[%0d]: got done=%b err=%b ok=%b sum=%h ce=%b want 1 1 0 0000 0", k, done_o, err_o, ok_o, sum_o, sram_ce_o);
          end
        end
      end
      release_op();
      n_checks++;
      if (done_o !== 1'b0 || err_o !== 1'b0 || ok_o !== 1'b0 || sum_o !== 16'h0) begin
        n_fail++; $display("FAIL clear[%0d]: got done=%b err=%b ok=%b sum=%h want all 0", i, done_o, err_o, ok_o, sum_o);
      end
    end
    load_hdr(32'h40);
    sb.push_back(make_exp(32'h40, 20));
    do_op(32'h40, 20, 1'b0);
    e = sb.pop_front();
    n_checks++; if (g_to || g_sum !== e.sum || g_ok !== 1'b1 || g_lat !== e.lat) begin
      n_fail++; $display("FAIL restart: got to=%b sum=%h ok=%b lat=%0d want sum=%h ok=1 lat=%0d", g_to, g_sum, g_ok, g_lat, e.sum, e.lat);
    end
    release_op();
  endtask

  task automatic test_reset_midop();
    exp_t e;
    load_hdr(32'h40);
    @(negedge clk);
    field_start_i = 32'h40; field_len_i = 32'd20; start_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sram_ce_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_midop: got ce=%b done=%b want 0 0", sram_ce_o, done_o);
    end
    start_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    sb.push_back(make_exp(32'h40, 20));
    do_op(32'h40, 20, 1'b0);
    e = sb.pop_front();
    n_checks++; if (g_to || g_sum !== e.sum || g_ok !== 1'b1 || g_lat !== e.lat || g_nrd !== e.nrd) begin
      n_fail++; $display("FAIL rerun_after_reset: got to=%b sum=%h ok=%b lat=%0d reads=%0d want sum=%h ok=1 lat=%0d reads=%0d",
                         g_to, g_sum, g_ok, g_lat, g_nrd, e.sum, e.lat, e.nrd);
    end
    release_op();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    sram_data_i = '0;
    test_reset();
    test_ipv4();
    test_odd_len();
    test_reject_hold();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
